sram_access_ctrl: RTL and testbench

//  Multi-cycle data-memory controller between the EXE stage and the MEM stage.
//  - Takes MEM_R_EN / MEM_W_EN, the ALU_result address and the val_Rm store data.
//  - Sequences a fixed-latency SRAM access.
//  - Drops ready while an access is in flight; the hazard unit freezes every pipeline register on !ready.

---
 rtl/arm_pkg.sv | 12 +
 rtl/sram_access_ctrl.sv | 116 +++++++++++
 tb/tb_sram_access_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the data-memory path of the pipeline.
package arm_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_ACCESS,
    MEM_DONE
  } mem_state_t;

  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_access_ctrl.sv
// Multi-cycle SRAM controller between EXE and MEM; holds ready low for the
// whole fixed-latency access so the hazard unit freezes the pipeline.
module sram_access_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_WDATA,
  input  logic [DATA_W-1:0] SRAM_RDATA,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  localparam int unsigned     CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;

  logic req;
  logic is_wr;
  logic is_rd;

  // A simultaneous read and write request is treated as a pure write.
  assign req   = MEM_R_EN | MEM_W_EN;
  assign is_wr = MEM_W_EN;
  assign is_rd = MEM_R_EN & ~MEM_W_EN;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_n_d  = we_n_q;
    oe_n_d  = oe_n_q;
    ready   = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = MEM_ACCESS;
          cnt_d   = '0;
          // Byte offset from the SRAM window, modulo 2^32, converted to a word index.
          addr_d  = ADDR_W'((addr - BASE_ADDR) >> 2);
          wdata_d = wdata;
          we_n_d  = ~is_wr;
          oe_n_d  = ~is_rd;
        end
      end
      MEM_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (!oe_n_q) begin
            rdata_d = SRAM_RDATA;
          end
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          state_d = MEM_DONE;
        end
      end
      MEM_DONE: begin
        ready   = 1'b1;
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

  assign rdata      = rdata_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_WDATA = wdata_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: reset abort, loads, stores,
// back-to-back, read/write collision and mid-access flush with address wrap.
module tb_sram_access_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_WDATA;
  logic [DATA_W-1:0] SRAM_RDATA;
  logic              SRAM_WE_N;
  logic              SRAM_OE_N;

  logic [DATA_W-1:0] sram_rd_val;
  assign SRAM_RDATA = sram_rd_val;

  int passed = 0;
  int total  = 0;

  // Observations collected by do_access
  int                stall;
  int                we_low;
  int                oe_low;
  logic              both_low;
  logic [ADDR_W-1:0] addr_seen;
  logic [DATA_W-1:0] wdata_seen;

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .WAIT_CYCLES(5),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (MEM_R_EN),
    .MEM_W_EN  (MEM_W_EN),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_WDATA(SRAM_WDATA),
    .SRAM_RDATA(SRAM_RDATA),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  // Called at a negedge with the DUT idle; returns in the first ready cycle.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at);
    MEM_R_EN   = r;
    MEM_W_EN   = w;
    addr       = a;
    wdata      = d;
    stall      = 0;
    we_low     = 0;
    oe_low     = 0;
    both_low   = 1'b0;
    addr_seen  = '0;
    wdata_seen = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready) break;
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (!SRAM_WE_N && !SRAM_OE_N) both_low = 1'b1;
      if (stall == 1) begin
        addr_seen  = SRAM_ADDR;
        wdata_seen = SRAM_WDATA;
      end
      stall++;
      if (stall == 2) begin
        addr  = a ^ 32'h0000_0040;
        wdata = ~d;
      end
      if (stall == drop_at) begin
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        addr     = '1;
        wdata    = '1;
      end
      @(negedge clk);
    end
  endtask

  task automatic end_access();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; addr = '0; wdata = '0;
    sram_rd_val = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (SRAM_WE_N !== 1'b1) $display("FAIL rst_we_n: got %b exp 1", SRAM_WE_N); else passed++;
    total++; if (SRAM_OE_N !== 1'b1) $display("FAIL rst_oe_n: got %b exp 1", SRAM_OE_N); else passed++;
    total++; if (SRAM_ADDR !== 16'd0) $display("FAIL rst_addr: got %h exp 0", SRAM_ADDR); else passed++;
    total++; if (rdata !== 32'd0) $display("FAIL rst_rdata: got %h exp 0", rdata); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b exp 1", ready); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_store();
    MEM_W_EN = 1'b1; addr = 32'd1032; wdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    #1;
    total++; if (SRAM_WE_N !== 1'b0) $display("FAIL abort_pre_we_n: got %b exp 0", SRAM_WE_N); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (SRAM_WE_N !== 1'b1) $display("FAIL abort_we_n: got %b exp 1", SRAM_WE_N); else passed++;
    total++; if (SRAM_WDATA !== 32'd0) $display("FAIL abort_wdata: got %h exp 0", SRAM_WDATA); else passed++;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b exp 1", ready); else passed++;
    total++; if (rdata !== 32'd0) $display("FAIL abort_rdata: got %h exp 0", rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 0);
    total++; if (stall !== 6) $display("FAIL store_stall: got %0d exp 6", stall); else passed++;
    total++; if (we_low !== 5) $display("FAIL store_we_low: got %0d exp 5", we_low); else passed++;
    total++; if (oe_low !== 0) $display("FAIL store_oe_low: got %0d exp 0", oe_low); else passed++;
    total++; if (addr_seen !== 16'd2) $display("FAIL store_addr: got %h exp 2", addr_seen); else passed++;
    total++; if (wdata_seen !== 32'hDEAD_BEEF) $display("FAIL store_wdata: got %h exp deadbeef", wdata_seen); else passed++;
    total++; if (SRAM_WE_N !== 1'b1) $display("FAIL store_done_we_n: got %b exp 1", SRAM_WE_N); else passed++;
    end_access();
    #1;
    total++; if (ready !== 1'b1) $display("FAIL store_idle_ready: got %b exp 1", ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_load();
    sram_rd_val = 32'h1234_5678;
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 0);
    total++; if (stall !== 6) $display("FAIL load_stall: got %0d exp 6", stall); else passed++;
    total++; if (oe_low !== 5) $display("FAIL load_oe_low: got %0d exp 5", oe_low); else passed++;
    total++; if (we_low !== 0) $display("FAIL load_we_low: got %0d exp 0", we_low); else passed++;
    total++; if (addr_seen !== 16'd1) $display("FAIL load_addr: got %h exp 1", addr_seen); else passed++;
    total++; if (rdata !== 32'h1234_5678) $display("FAIL load_rdata: got %h exp 12345678", rdata); else passed++;
    total++; if (both_low !== 1'b0) $display("FAIL load_both_low: got %b exp 0", both_low); else passed++;
    end_access();
    sram_rd_val = 32'hFFFF_FFFF;
    do_access(1'b0, 1'b1, 32'd1036, 32'hCAFE_F00D, 0);
    end_access();
    #1;
    total++; if (rdata !== 32'h1234_5678) $display("FAIL load_rdata_held: got %h exp 12345678", rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sram_rd_val = 32'hA5A5_0001;
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, 0);
    total++; if (stall !== 6) $display("FAIL b2b_load_stall: got %0d exp 6", stall); else passed++;
    total++; if (addr_seen !== 16'd4) $display("FAIL b2b_load_addr: got %h exp 4", addr_seen); else passed++;
    end_access();
    do_access(1'b0, 1'b1, 32'd1044, 32'h0BAD_F00D, 0);
    total++; if (stall !== 6) $display("FAIL b2b_store_stall: got %0d exp 6", stall); else passed++;
    total++; if (addr_seen !== 16'd5) $display("FAIL b2b_store_addr: got %h exp 5", addr_seen); else passed++;
    total++; if (wdata_seen !== 32'h0BAD_F00D) $display("FAIL b2b_store_wdata: got %h exp 0badf00d", wdata_seen); else passed++;
    total++; if (rdata !== 32'hA5A5_0001) $display("FAIL b2b_rdata: got %h exp a5a50001", rdata); else passed++;
    end_access();
  endtask

  task automatic test_both_req();
    sram_rd_val = 32'h9999_9999;
    do_access(1'b1, 1'b1, 32'd1048, 32'h1111_2222, 0);
    total++; if (we_low !== 5) $display("FAIL both_we_low: got %0d exp 5", we_low); else passed++;
    total++; if (oe_low !== 0) $display("FAIL both_oe_low: got %0d exp 0", oe_low); else passed++;
    total++; if (addr_seen !== 16'd6) $display("FAIL both_addr: got %h exp 6", addr_seen); else passed++;
    total++; if (rdata !== 32'hA5A5_0001) $display("FAIL both_rdata: got %h exp a5a50001", rdata); else passed++;
    end_access();
  endtask

  task automatic test_flush_wrap();
    do_access(1'b0, 1'b1, 32'd1020, 32'h0000_0055, 3);
    total++; if (stall !== 6) $display("FAIL flush_stall: got %0d exp 6", stall); else passed++;
    total++; if (we_low !== 5) $display("FAIL flush_we_low: got %0d exp 5", we_low); else passed++;
    total++; if (addr_seen !== 16'hFFFF) $display("FAIL flush_wrap_addr: got %h exp ffff", addr_seen); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL flush_done_ready: got %b exp 1", ready); else passed++;
    end_access();
    #1;
    total++; if (ready !== 1'b1) $display("FAIL flush_idle_ready: got %b exp 1", ready); else passed++;
    total++; if (SRAM_WE_N !== 1'b1 || SRAM_OE_N !== 1'b1)
      $display("FAIL flush_idle_strobes: got we_n=%b oe_n=%b exp 1/1", SRAM_WE_N, SRAM_OE_N);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_store();
    test_store();
    test_load();
    test_back_to_back();
    test_both_req();
    test_flush_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
